ntt_stage_sched: RTL and testbench



---
 rtl/ntt_stage_sched.sv | 210 +++++++++++++++++++++
 tb/tb_ntt_stage_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sched.sv
// -----------------------------------------------------------------------------
// ntt_stage_sched
//
// Stage sequencer for the NWC/NTT address-generation path. A start request
// runs the radix-k1 AGU once per k1 stage (stage index on l_k1), then runs the
// radix-k2 (last-stage) AGU once, then pulses sched_done. Between stages both
// AGU enables are held low for DRAIN_CYCLES+1 cycles. This gap lets each AGU's
// internal counter reset and lets the butterfly pipeline empty.
//
// Optional feature: define NTT_SCHED_TIMEOUT_EN to build a per-RUN-state
// watchdog. If the watchdog expires, the FSM returns to IDLE and sched_err is
// raised and held. Without the macro, sched_err is tied to 0 and the RUN
// states wait indefinitely.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   start        in   begin a full transform (sampled only in IDLE)
//   abort        in   synchronous abort; returns to IDLE from any state
//   agu_done_k1  in   done pulse from the k1 AGU
//   agu_done_k2  in   done pulse from the k2 AGU
//   agu_en_k1    out  enable to the k1 AGU
//   agu_en_k2    out  enable to the k2 AGU
//   l_k1         out  current k1 stage index (D_WIDTH bits)
//   busy         out  high in every state except IDLE
//   sched_done   out  one-cycle completion pulse
//   sched_err    out  sticky watchdog error
// -----------------------------------------------------------------------------
module ntt_stage_sched #(
    parameter int          D_WIDTH        = 32,
    parameter int unsigned NUM_K1_STAGES  = 3,
    parameter int unsigned DRAIN_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               agu_done_k1,
    input  logic               agu_done_k2,
    output logic               agu_en_k1,
    output logic               agu_en_k2,
    output logic [D_WIDTH-1:0] l_k1,
    output logic               busy,
    output logic               sched_done,
    output logic               sched_err
);

    typedef enum logic [2:0] {
        IDLE,
        K1_RUN,
        K1_DRAIN,
        K2_RUN,
        K2_DRAIN,
        DONE
    } state_t;

    // The drain counter needs at least one bit, even when DRAIN_CYCLES is 0.
    localparam int DRAIN_W = ($clog2(DRAIN_CYCLES + 1) > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);

    // Index of the last k1 stage. It is never used when there are no k1 stages.
    localparam logic [D_WIDTH-1:0] L_LAST =
        (NUM_K1_STAGES > 0) ? D_WIDTH'(NUM_K1_STAGES - 1) : '0;

    state_t               state;
    logic [DRAIN_W-1:0]   drain_cnt;

`ifdef NTT_SCHED_TIMEOUT_EN
    localparam int WDOG_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog;
    logic              err_q;

    assign sched_err = err_q;
`else
    assign sched_err = 1'b0;
`endif

    // Every output is assigned together with the state it belongs to. As a
    // result, each output is a flop that already reflects the state entered
    // on this edge.
    // NOTE: all state and outputs use non-blocking assignments. Each branch
    // therefore reads the pre-edge values, however the branches are ordered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            agu_en_k1  <= 1'b0;
            agu_en_k2  <= 1'b0;
            l_k1       <= '0;
            busy       <= 1'b0;
            sched_done <= 1'b0;
`ifdef NTT_SCHED_TIMEOUT_EN
            wdog       <= '0;
            err_q      <= 1'b0;
`endif
        end else if (abort) begin
            // Abort outranks every transition, including a start in IDLE.
            state      <= IDLE;
            drain_cnt  <= '0;
            agu_en_k1  <= 1'b0;
            agu_en_k2  <= 1'b0;
            l_k1       <= '0;
            busy       <= 1'b0;
            sched_done <= 1'b0;
        end else begin
            sched_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        l_k1 <= '0;
                        busy <= 1'b1;
`ifdef NTT_SCHED_TIMEOUT_EN
                        wdog  <= '0;
                        err_q <= 1'b0;
`endif
                        if (NUM_K1_STAGES > 0) begin
                            state     <= K1_RUN;
                            agu_en_k1 <= 1'b1;
                        end else begin
                            state     <= K2_RUN;
                            agu_en_k2 <= 1'b1;
                        end
                    end
                end

                K1_RUN: begin
                    if (agu_done_k1) begin
                        state     <= K1_DRAIN;
                        agu_en_k1 <= 1'b0;
                        drain_cnt <= '0;
                    end
`ifdef NTT_SCHED_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        state     <= IDLE;
                        agu_en_k1 <= 1'b0;
                        busy      <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end

                K1_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
`ifdef NTT_SCHED_TIMEOUT_EN
                        wdog <= '0;
`endif
                        if (l_k1 == L_LAST) begin
                            state     <= K2_RUN;
                            agu_en_k2 <= 1'b1;
                        end else begin
                            state     <= K1_RUN;
                            agu_en_k1 <= 1'b1;
                            l_k1      <= l_k1 + 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                K2_RUN: begin
                    if (agu_done_k2) begin
                        state     <= K2_DRAIN;
                        agu_en_k2 <= 1'b0;
                        drain_cnt <= '0;
                    end
`ifdef NTT_SCHED_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        state     <= IDLE;
                        agu_en_k2 <= 1'b0;
                        busy      <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end

                K2_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state      <= DONE;
                        sched_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // A start seen here is dropped; it is sampled again only
                    // once the FSM is back in IDLE.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    agu_en_k1 <= 1'b0;
                    agu_en_k2 <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_stage_sched.sv
// -----------------------------------------------------------------------------
// tb_ntt_stage_sched
//
// Directed bench for ntt_stage_sched. It uses two instances:
//   dut_a: NUM_K1_STAGES=3, DRAIN_CYCLES=2, TIMEOUT_CYCLES=16
//   dut_b: NUM_K1_STAGES=0, DRAIN_CYCLES=0
// The watchdog scenario is compiled only when NTT_SCHED_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_ntt_stage_sched;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_start, a_abort, a_done1, a_done2;
    logic          a_en1, a_en2, a_busy, a_sdone, a_err;
    logic [DW-1:0] a_l;
    logic          b_start, b_abort, b_done1, b_done2;
    logic          b_en1, b_en2, b_busy, b_sdone, b_err;
    logic [DW-1:0] b_l;

    ntt_stage_sched #(
        .D_WIDTH(DW), .NUM_K1_STAGES(3), .DRAIN_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .agu_done_k1(a_done1), .agu_done_k2(a_done2),
        .agu_en_k1(a_en1), .agu_en_k2(a_en2), .l_k1(a_l),
        .busy(a_busy), .sched_done(a_sdone), .sched_err(a_err)
    );

    ntt_stage_sched #(
        .D_WIDTH(DW), .NUM_K1_STAGES(0), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .agu_done_k1(b_done1), .agu_done_k2(b_done2),
        .agu_en_k1(b_en1), .agu_en_k2(b_en2), .l_k1(b_l),
        .busy(b_busy), .sched_done(b_sdone), .sched_err(b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge. Inputs are also driven
    // there, so the next edge samples them.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observations gathered by run_a. Cycle 1 is the first cycle after start
    // has been sampled.
    int  k1_rises, k2_rises, done_pulses, done_cyc, k2_rise_cyc, busy_drop_cyc;
    int  l_bad, l_rise[4], gaps[4];
    bit  finished;

    // AGU model: done is driven in the 6th cycle of enable-high, which is
    // 5 cycles after the enable rises.
    task automatic run_a(input bit spurious, input bit do_abort,
                         input bit hold_start, input bit rst_k2);
        int en1_cnt = 0, en2_cnt = 0, low_cnt = 0, rises = 0;
        bit p1 = 1'b0, p2 = 1'b0, aborted = 1'b0, rst_now = 1'b0;
        k1_rises = 0; k2_rises = 0; done_pulses = 0; done_cyc = 0;
        k2_rise_cyc = 0; busy_drop_cyc = 0; l_bad = 0; finished = 1'b0;
        for (int i = 0; i < 4; i++) begin l_rise[i] = -1; gaps[i] = -1; end

        a_start = 1'b1;
        tick();
        if (!hold_start) a_start = 1'b0;

        for (int k = 1; k <= 200; k++) begin
            if (a_en1 && !p1) begin
                if (k1_rises < 4) l_rise[k1_rises] = int'(a_l);
                if (rises > 0 && rises <= 4) gaps[rises-1] = low_cnt;
                rises++; k1_rises++; low_cnt = 0;
            end
            if (a_en2 && !p2) begin
                k2_rise_cyc = k;
                if (rises > 0 && rises <= 4) gaps[rises-1] = low_cnt;
                rises++; k2_rises++; low_cnt = 0;
            end
            if (!a_en1 && !a_en2 && a_busy) low_cnt++;
            if (a_sdone) begin done_pulses++; done_cyc = k; end
            if (!a_busy && done_pulses > 0 && busy_drop_cyc == 0) busy_drop_cyc = k;
            if (spurious && a_en1 && k1_rises == 2 && a_l != 1) l_bad++;
            en1_cnt = a_en1 ? en1_cnt + 1 : 0;
            en2_cnt = a_en2 ? en2_cnt + 1 : 0;
            p1 = a_en1;
            p2 = a_en2;

            if (busy_drop_cyc != 0) begin finished = 1'b1; break; end

            a_done1 = (a_en1 && en1_cnt == 6) ||
                      (spurious && !a_en1 && !a_en2 && a_busy && k1_rises == 1);
            a_done2 = (a_en2 && en2_cnt == 6) ||
                      (spurious && a_en1 && k1_rises == 2 && en1_cnt == 2);
            a_abort = do_abort && a_en1 && k1_rises == 2 && en1_cnt == 2;
            aborted = a_abort;
            if (rst_k2 && a_en2 && en2_cnt == 2) begin
                rst = 1'b1; a_start = 1'b0; rst_now = 1'b1;
            end
            tick();

            if (aborted) begin
                a_abort = 1'b0; a_done1 = 1'b0; a_done2 = 1'b0;
                check("abort_en1", a_en1, 1'b0);
                check("abort_busy", a_busy, 1'b0);
                check("abort_l", a_l, 0);
                check("abort_sdone", a_sdone, 1'b0);
                finished = 1'b1;
                break;
            end
            if (rst_now) begin
                rst = 1'b0; a_done1 = 1'b0; a_done2 = 1'b0;
                check("rst_en1", a_en1, 1'b0);
                check("rst_en2", a_en2, 1'b0);
                check("rst_l", a_l, 0);
                check("rst_busy", a_busy, 1'b0);
                check("rst_sdone", a_sdone, 1'b0);
                finished = 1'b1;
                break;
            end
        end
        check("run_terminated", finished, 1'b1);
        a_start = 1'b0; a_done1 = 1'b0; a_done2 = 1'b0; a_abort = 1'b0;
    endtask

    // Expected results of an uninterrupted defaults run: k1 runs in cycles
    // 1-6, 10-15 and 19-24; k2 runs in cycles 28-33; sched_done in cycle 37;
    // busy low from cycle 38.
    task automatic check_full(input string pfx);
        check({pfx, "_k1_runs"}, k1_rises, 3);
        check({pfx, "_l0"}, l_rise[0], 0);
        check({pfx, "_l1"}, l_rise[1], 1);
        check({pfx, "_l2"}, l_rise[2], 2);
        check({pfx, "_gap0"}, gaps[0], 3);
        check({pfx, "_gap1"}, gaps[1], 3);
        check({pfx, "_gap2"}, gaps[2], 3);
        check({pfx, "_k2_runs"}, k2_rises, 1);
        check({pfx, "_k2_cyc"}, k2_rise_cyc, 28);
        check({pfx, "_done_cnt"}, done_pulses, 1);
        check({pfx, "_done_cyc"}, done_cyc, 37);
        check({pfx, "_idle_cyc"}, busy_drop_cyc, 38);
    endtask

    initial begin
        bit seen;
        int err_cyc;
        rst = 1'b1;
        a_start = 0; a_abort = 0; a_done1 = 0; a_done2 = 0;
        b_start = 0; b_abort = 0; b_done1 = 0; b_done2 = 0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_a_en1", a_en1, 1'b0);
        check("rst_a_en2", a_en2, 1'b0);
        check("rst_a_l", a_l, 0);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_a_sdone", a_sdone, 1'b0);
        check("rst_a_err", a_err, 1'b0);
        check("rst_b_busy", b_busy, 1'b0);

        // Plain full sequence.
        run_a(1'b0, 1'b0, 1'b0, 1'b0);
        check_full("norm");

        // Wrong-AGU done during stage 1 and k1 done during the drain are ignored.
        run_a(1'b1, 1'b0, 1'b0, 1'b0);
        check_full("spur");
        check("spur_l_stable", l_bad, 0);

        // Abort in stage 1: no completion follows, and a new start begins at stage 0.
        run_a(1'b0, 1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= a_sdone | a_busy;
            tick();
        end
        check("abort_quiet", seen, 1'b0);
        run_a(1'b0, 1'b0, 1'b0, 1'b0);
        check_full("restart");

        // Start held high through the whole run, including the DONE cycle:
        // no restart occurs.
        run_a(1'b0, 1'b0, 1'b1, 1'b0);
        check_full("hold");
        tick();
        check("hold_no_restart_busy", a_busy, 1'b0);
        check("hold_no_restart_en1", a_en1, 1'b0);

        // Start held high, then rst in K2_RUN.
        run_a(1'b0, 1'b0, 1'b1, 1'b1);
        check("rstk2_k1_runs", k1_rises, 3);
        check("rstk2_l2", l_rise[2], 2);
        check("rstk2_no_done", done_pulses, 0);
        tick();
        check("rstk2_idle", a_busy, 1'b0);

        // No k1 stages, no drain: k2 is enabled one cycle after start, and a
        // done at cycle t gives sched_done at t+2.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_en2_rise", b_en2, 1'b1);
        check("b_en1_rise", b_en1, 1'b0);
        check("b_l", b_l, 0);
        check("b_busy", b_busy, 1'b1);
        tick();
        b_done2 = 1'b1;  // cycle t
        tick();
        b_done2 = 1'b0;  // cycle t+1
        check("b_drain_en2", b_en2, 1'b0);
        check("b_drain_sdone", b_sdone, 1'b0);
        tick();          // cycle t+2
        check("b_sdone", b_sdone, 1'b1);
        check("b_done_busy", b_busy, 1'b1);
        tick();
        check("b_sdone_once", b_sdone, 1'b0);
        check("b_idle", b_busy, 1'b0);
        check("b_en1_never", b_en1, 1'b0);

`ifdef NTT_SCHED_TIMEOUT_EN
        // The AGU never answers. The watchdog fires 16 cycles after the
        // enable rises, which is cycle 17 counting the rise as cycle 1.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        err_cyc = 0;
        for (int k = 1; k <= 100; k++) begin
            if (a_err) begin err_cyc = k; break; end
            tick();
        end
        check("wdog_cyc", err_cyc, 17);
        check("wdog_busy", a_busy, 1'b0);
        check("wdog_en1", a_en1, 1'b0);
        check("wdog_sdone", a_sdone, 1'b0);
        tick();
        check("wdog_sticky", a_err, 1'b1);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("wdog_clear", a_err, 1'b0);
        check("wdog_restart", a_en1, 1'b1);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
`else
        err_cyc = 0;
        check("err_tied", a_err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
